// File: rtl/sw_debounce.sv
// sw_debounce: per-bit switch conditioning for the board sw_in bus.
// Each bit has a 2-flop synchronizer followed by a consecutive-sample
// debounce counter. A new level is accepted only after DEBOUNCE_CYCLES
// consecutive synchronized samples disagree with the current output.
//
// Build option: define SW_DEBOUNCE_EDGE_EN to compile in the registered
// one-cycle sw_rise/sw_fall strobes. Without it both strobe ports are
// tied to 0 and the sw_db path is unchanged.
//
// Per-bit behaviour (no encoded FSM, the counter carries the state):
//   STABLE  | cnt == 0 and sync2 == sw_db
//   QUALIFY | cnt > 0, or sync2 != sw_db
module sw_debounce #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_db,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_db;
  logic [CW-1:0]    r_cnt [WIDTH];
  logic [WIDTH-1:0] w_mismatch;
  logic [WIDTH-1:0] w_accept;

  // Accept fires on the evaluation that finds the counter already at its
  // terminal value with the mismatch still present, so it never wraps.
  always_comb begin
    w_mismatch = r_sync2 ^ r_db;
    w_accept   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_accept[i] = w_mismatch[i] && (r_cnt[i] == CNT_LAST);
    end
  end

  // Two-flop synchronizer for the asynchronous raw switch levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= sw_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Per-bit qualification counter; any agreeing sample restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (!w_mismatch[i] || w_accept[i]) begin
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  // Debounced level flips exactly on the bits being accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_db <= '0;
    end else begin
      r_db <= r_db ^ w_accept;
    end
  end

  assign sw_db = r_db;

`ifdef SW_DEBOUNCE_EDGE_EN
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;

  // Strobes register alongside r_db so they line up with the new level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      r_rise <= w_accept & r_sync2;
      r_fall <= w_accept & ~r_sync2;
    end
  end

  assign sw_rise = r_rise;
  assign sw_fall = r_fall;
`else
  assign sw_rise = '0;
  assign sw_fall = '0;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce with WIDTH=8, DEBOUNCE_CYCLES=4. A behavioural
// model (raw delay line plus a window of the last D synchronized samples)
// is compared against the DUT every cycle; directed scenarios add literal
// expectations for latency, bounce rejection and reset behaviour.
module tb_sw_debounce;

  localparam int W = 8;
  localparam int D = 4;
`ifdef SW_DEBOUNCE_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif
  localparam logic [W-1:0] EMASK = EDGE_EN ? 8'hFF : 8'h00;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] sw_raw;
  logic [W-1:0] sw_db;
  logic [W-1:0] sw_rise;
  logic [W-1:0] sw_fall;

  int n_checks = 0;
  int n_errors = 0;

  sw_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sw_raw (sw_raw),
    .sw_db  (sw_db),
    .sw_rise(sw_rise),
    .sw_fall(sw_fall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: the value seen by the qualifier at an edge is the raw
  // level sampled two edges earlier. A bit flips once the last D seen
  // samples all disagree with it and D evaluations have passed since its
  // previous flip (or reset).
  logic [W-1:0] m_d1, m_d2, m_db, m_rise, m_fall;
  logic [W-1:0] m_hist [D];
  int           m_since [W];

  always @(posedge clk or negedge rst_n) begin
    logic [W-1:0] seen;
    bit all_mis;
    if (!rst_n) begin
      m_d1 = '0; m_d2 = '0; m_db = '0; m_rise = '0; m_fall = '0;
      for (int k = 0; k < D; k++) m_hist[k] = '0;
      for (int i = 0; i < W; i++) m_since[i] = 0;
    end else begin
      seen = m_d2;
      m_d2 = m_d1;
      m_d1 = sw_raw;
      for (int k = D - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = seen;
      m_rise = '0;
      m_fall = '0;
      for (int i = 0; i < W; i++) begin
        if (m_since[i] < D) m_since[i]++;
        all_mis = 1'b1;
        for (int k = 0; k < D; k++) if (m_hist[k][i] == m_db[i]) all_mis = 1'b0;
        if (all_mis && m_since[i] >= D) begin
          m_db[i] = ~m_db[i];
          if (m_db[i]) m_rise[i] = EDGE_EN;
          else         m_fall[i] = EDGE_EN;
          m_since[i] = 0;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("model_db",   sw_db,   m_db);
    check("model_rise", sw_rise, m_rise);
    check("model_fall", sw_fall, m_fall);
  end

  // Called right after driving a new raw value before edge E0: checks the
  // old level holds through E0+4, the new one appears after E0+5 with its
  // strobes, and the strobes drop one cycle later.
  task automatic expect_accept(input logic [W-1:0] old_db, input logic [W-1:0] new_db,
                               input logic [W-1:0] rise, input logic [W-1:0] fall);
    for (int j = 0; j < 5; j++) begin
      @(posedge clk); #1;
    end
    check("db_hold_E0+4", sw_db, old_db);
    @(posedge clk); #1;
    check("db_new_E0+5", sw_db, new_db);
    check("rise_E0+5", sw_rise, rise & EMASK);
    check("fall_E0+5", sw_fall, fall & EMASK);
    @(posedge clk); #1;
    check("rise_clear", sw_rise, 8'h00);
    check("fall_clear", sw_fall, 8'h00);
  endtask

  initial begin
    int hold;
    rst_n  = 1'b0;
    sw_raw = 8'hFF;

    // Reset held with all switches high.
    repeat (3) @(posedge clk);
    #1;
    check("rst_db",   sw_db,   8'h00);
    check("rst_rise", sw_rise, 8'h00);
    check("rst_fall", sw_fall, 8'h00);
    rst_n = 1'b1;
    expect_accept(8'h00, 8'hFF, 8'hFF, 8'h00);

    // Clean steps, including multi-bit rises on one edge.
    sw_raw = 8'h00;
    expect_accept(8'hFF, 8'h00, 8'h00, 8'hFF);
    sw_raw = 8'h01;
    expect_accept(8'h00, 8'h01, 8'h01, 8'h00);
    sw_raw = 8'h0F;
    expect_accept(8'h01, 8'h0F, 8'h0E, 8'h00);

    // Simultaneous rise and fall on disjoint bits.
    sw_raw = 8'hF0;
    expect_accept(8'h0F, 8'hF0, 8'hF0, 8'h0F);

    // Bounce on bit 3 shorter than the qualification window.
    sw_raw[3] = 1'b1; @(posedge clk); #1;
    sw_raw[3] = 1'b0; @(posedge clk); #1;
    sw_raw[3] = 1'b1; @(posedge clk); #1;
    sw_raw[3] = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(posedge clk); #1;
      check("bounce_db",   sw_db,   8'hF0);
      check("bounce_rise", sw_rise, 8'h00);
      check("bounce_fall", sw_fall, 8'h00);
    end

    // Late bounce on bit 2: three high samples, one low, then held high.
    sw_raw[2] = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    sw_raw[2] = 1'b0;
    @(posedge clk); #1;
    sw_raw[2] = 1'b1;
    expect_accept(8'hF0, 8'hF4, 8'h04, 8'h00);

    // Reset during qualification discards the partial count.
    sw_raw = 8'hF5;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_db", sw_db, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    check("midrst_db_hold", sw_db, 8'h00);
    check("midrst_rise", sw_rise, 8'h00);
    rst_n = 1'b1;
    expect_accept(8'h00, 8'hF5, 8'hF5, 8'h00);

    // Randomized levels and bounces with occasional resets; model-checked.
    hold = 0;
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #2;
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b1;
      end
      if (hold == 0) begin
        case ($urandom_range(0, 2))
          0: begin sw_raw = 8'($urandom); hold = $urandom_range(4, 12); end
          1: begin sw_raw[$urandom_range(0, W-1)] ^= 1'b1; hold = $urandom_range(0, 3); end
          default: begin sw_raw ^= 8'($urandom); hold = $urandom_range(0, 6); end
        endcase
      end else begin
        hold--;
      end
    end
    repeat (12) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
